rl_traceback: RTL

- Downstream consumer of the race-logic alignment array's per-cell edge_vec results (hor/diag/ver first-arrival flags).
- Buffers the SEQ_LEN x SEQ_LEN edge matrix as cells report it.
- On start, walks from the bottom-right cell to the origin and emits one alignment op per handshake on a valid/ready stream to the result formatter.

---
 rtl/rl_traceback.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/rl_traceback.sv
// rl_traceback: buffers the alignment array's per-cell edge vectors and walks them
// from the bottom-right cell back to the origin, streaming one op per handshake.
module rl_traceback #(
    parameter int NUM_SYMBOLS = 4,
    parameter int SEQ_LEN     = 5,
    parameter int IDX_W       = $clog2(SEQ_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_row,
    input  logic [IDX_W-1:0] wr_col,
    input  logic [2:0]       wr_edge,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [1:0]       op_code,
    output logic [IDX_W-1:0] op_row,
    output logic [IDX_W-1:0] op_col
);

    typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} state_t;

    localparam logic [1:0]       OP_DIAG  = 2'b00;
    localparam logic [1:0]       OP_HOR   = 2'b01;
    localparam logic [1:0]       OP_VER   = 2'b10;
    localparam logic [1:0]       OP_END   = 2'b11;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

    if (NUM_SYMBOLS < 1 || SEQ_LEN < 2) begin : g_param_check
        $error("rl_traceback: unsupported NUM_SYMBOLS/SEQ_LEN");
    end

    state_t           state, state_nx;
    logic [2:0]       mem [SEQ_LEN][SEQ_LEN];
    logic             wr_in_range;

    logic [IDX_W-1:0] tgt_row, tgt_col;
    logic [2:0]       cell_edge, masked;
    logic             at_origin, dead_end;
    logic [1:0]       tgt_code;

    logic             busy_nx, done_nx, err_nx, op_valid_nx;
    logic [1:0]       op_code_nx;
    logic [IDX_W-1:0] op_row_nx, op_col_nx;

    assign wr_in_range = (32'(wr_row) < SEQ_LEN) && (32'(wr_col) < SEQ_LEN);

    // Edge matrix only accepts writes between walks so a walk sees a frozen matrix.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < SEQ_LEN; r++) begin
                for (int c = 0; c < SEQ_LEN; c++) begin
                    mem[r][c] <= 3'b000;
                end
            end
        end else if (state == S_IDLE && wr_en && wr_in_range) begin
            mem[wr_row][wr_col] <= wr_edge;
        end
    end

    // The op register always holds the current cursor; the target is the cell the
    // next op will leave, i.e. the start corner or the neighbour the current op points to.
    always_comb begin
        tgt_row = op_row;
        tgt_col = op_col;
        if (state == S_IDLE) begin
            tgt_row = LAST_IDX;
            tgt_col = LAST_IDX;
        end else begin
            case (op_code)
                OP_DIAG: begin
                    tgt_row = op_row - IDX_W'(1);
                    tgt_col = op_col - IDX_W'(1);
                end
                OP_HOR:  tgt_col = op_col - IDX_W'(1);
                OP_VER:  tgt_row = op_row - IDX_W'(1);
                default: ;
            endcase
        end
    end

    // Forward a same-cycle write so a start issued alongside it sees the new edge.
    always_comb begin
        cell_edge = mem[tgt_row][tgt_col];
        if (state == S_IDLE && wr_en && wr_row == tgt_row && wr_col == tgt_col) begin
            cell_edge = wr_edge;
        end
        masked = cell_edge;
        if (tgt_row == '0) begin
            masked[1] = 1'b0;
            masked[0] = 1'b0;
        end
        if (tgt_col == '0) begin
            masked[2] = 1'b0;
            masked[1] = 1'b0;
        end
        at_origin = (tgt_row == '0) && (tgt_col == '0);
        dead_end  = !at_origin && (masked == 3'b000);
        if (at_origin)      tgt_code = OP_END;
        else if (masked[1]) tgt_code = OP_DIAG;
        else if (masked[2]) tgt_code = OP_HOR;
        else                tgt_code = OP_VER;
    end

    always_comb begin
        state_nx    = state;
        busy_nx     = busy;
        done_nx     = 1'b0;
        err_nx      = 1'b0;
        op_valid_nx = op_valid;
        op_code_nx  = op_code;
        op_row_nx   = op_row;
        op_col_nx   = op_col;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (dead_end) begin
                        err_nx = 1'b1;
                    end else begin
                        state_nx    = S_WALK;
                        busy_nx     = 1'b1;
                        op_valid_nx = 1'b1;
                        op_code_nx  = tgt_code;
                        op_row_nx   = tgt_row;
                        op_col_nx   = tgt_col;
                    end
                end
            end
            S_WALK: begin
                if (op_valid && op_ready) begin
                    if (op_code == OP_END) begin
                        state_nx    = S_DONE;
                        busy_nx     = 1'b0;
                        done_nx     = 1'b1;
                        op_valid_nx = 1'b0;
                    end else if (dead_end) begin
                        state_nx    = S_IDLE;
                        busy_nx     = 1'b0;
                        err_nx      = 1'b1;
                        op_valid_nx = 1'b0;
                    end else begin
                        op_code_nx  = tgt_code;
                        op_row_nx   = tgt_row;
                        op_col_nx   = tgt_col;
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx    = S_IDLE;
                busy_nx     = 1'b0;
                op_valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            op_valid <= 1'b0;
            op_code  <= 2'b00;
            op_row   <= '0;
            op_col   <= '0;
        end else begin
            state    <= state_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            err      <= err_nx;
            op_valid <= op_valid_nx;
            op_code  <= op_code_nx;
            op_row   <= op_row_nx;
            op_col   <= op_col_nx;
        end
    end

endmodule
